sa_act_feeder: RTL

SA_ACT_FEEDER -- requirements
Module: sa_act_feeder

---
 rtl/sa_act_feeder.sv | 116 +++++++++++
 1 files changed

// File: rtl/sa_act_feeder.sv
// sa_act_feeder: FIFO-buffered activation feeder that skews each vector across systolic-array rows
// Ports: clk/rst (async active-high); i_valid/o_ready/i_act/i_last input handshake;
//        o_act/o_act_valid skewed lanes (lane r delayed r cycles); o_mode/o_busy PE mode;
//        o_done pulses when a tile's last vector reaches the bottom lane.
module sa_act_feeder #(
    parameter int ROWS          = 4,
    parameter int MUL_DATAWIDTH = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [ROWS*MUL_DATAWIDTH-1:0] i_act,
    input  logic                          i_last,
    output logic [ROWS*MUL_DATAWIDTH-1:0] o_act,
    output logic [ROWS-1:0]               o_act_valid,
    output logic                          o_mode,
    output logic                          o_busy,
    output logic                          o_done
);
    localparam int MW = MUL_DATAWIDTH;
    localparam int DW = ROWS * MW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW:0]     wr_q, rd_q;
    logic [DW:0]     mem_q [FIFO_DEPTH];
    logic [ROWS-1:0] last_q;
    logic            full, empty, push, pop;
    logic [DW:0]     head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full    = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign empty   = wr_q == rd_q;
    assign o_ready = !full;
    assign push    = i_valid && !full;
    assign pop     = !empty && state_q != DRAIN;
    assign head    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {i_last, i_act};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            wr_q    <= wr_q + (AW+1)'(push);
            rd_q    <= rd_q + (AW+1)'(pop);
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, STREAM: begin
                if (pop) begin
                    // A single-row array has nothing to flush, so a last vector ends the tile at once.
                    state_d = head[DW] ? (ROWS == 1 ? IDLE : DRAIN) : STREAM;
                    cnt_d   = head[DW] ? CW'(ROWS - 1) : cnt_q;
                end
            end
            DRAIN: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = cnt_q == CW'(1) ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane r is a chain of r+1 registers; bubbles enter as zero data with valid low.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [MW-1:0] d_q [r+1];
        logic [r:0]    v_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= r; j++) d_q[j] <= '0;
                v_q <= '0;
            end else begin
                d_q[0] <= pop ? head[r*MW +: MW] : '0;
                v_q[0] <= pop;
                for (int j = 1; j <= r; j++) begin
                    d_q[j] <= d_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end
        assign o_act[r*MW +: MW] = d_q[r];
        assign o_act_valid[r]    = v_q[r];
    end

    // The last flag rides alongside the bottom lane so o_done lines up with its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
        end else begin
            last_q[0] <= pop && head[DW];
            for (int j = 1; j < ROWS; j++) last_q[j] <= last_q[j-1];
        end
    end

    assign o_done = last_q[ROWS-1];
    assign o_mode = state_q != IDLE;
    assign o_busy = o_mode;
endmodule
